// File: rtl/counter_load_oe_param_if.sv
// rtl/counter_load_oe_param_if.sv - control/data bundle for the parametrised load/OE counter
interface counter_load_oe_param_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             LD;
  logic             OE;
  logic             UP;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Y;
  logic             TC;
  logic             DONE;

  modport master (
    output EN, LD, OE, UP, MODE, D,
    input  Y, TC, DONE
  );

  modport slave (
    input  EN, LD, OE, UP, MODE, D,
    output Y, TC, DONE
  );
endinterface

// File: rtl/counter_load_oe_param.sv
// rtl/counter_load_oe_param.sv - up/down modulus counter with load, output enable and wrap/saturate/one-shot modes
module counter_load_oe_param #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic                     clk,
  input  logic                     RST_N,
  counter_load_oe_param_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] tv;
  logic             at_tv;
  logic             running;

  // Terminal value follows UP immediately so TC can be used for cascading in either direction
  assign tv      = bus.UP ? MAX_V : ZERO;
  assign at_tv   = (cnt_q == tv);
  assign running = (state_q == RUN);

  // RST_N gating keeps TC low while reset is held even when cnt=0 matches a down-count terminal
  assign bus.TC   = RST_N & bus.EN & at_tv & ~bus.LD & running;
  assign bus.Y    = bus.OE ? cnt_q : ZERO;
  assign bus.DONE = done_q;

  // Next-state: load beats enable; HALT ignores EN; wrap is explicit so non-power-of-two moduli work
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done_q;
    state_d = state_q;
    if (bus.LD) begin
      cnt_d   = (bus.D > MAX_V) ? MAX_V : bus.D;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (running && bus.EN) begin
      if (!at_tv) begin
        cnt_d = bus.UP ? (cnt_q + ONE) : (cnt_q - ONE);
      end else begin
        case (bus.MODE)
          MODE_SAT: cnt_d = cnt_q;
          MODE_ONCE: begin
            done_d  = 1'b1;
            state_d = HALT;
          end
          default: cnt_d = bus.UP ? ZERO : MAX_V;
        endcase
      end
    end
  end

  // Count, sticky DONE and RUN/HALT state, all cleared asynchronously
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= ZERO;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_counter_load_oe_param.sv
// tb/tb_counter_load_oe_param.sv - randomized model-checked bench for a two-stage cascade of counter_load_oe_param
module tb_counter_load_oe_param;

  localparam int W  = 4;
  localparam int MV = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, ld, oe, up;
  logic [1:0]   mode;
  logic [W-1:0] d;

  int errors = 0;
  int checks = 0;

  // reference state: plain integers
  int m_cnt0, m_cnt1;
  bit m_done0, m_halt0;
  int falls0, falls1, prev_y0, prev_y1;

  always #5 clk = ~clk;

  counter_load_oe_param_if #(.WIDTH(W)) bus0 ();
  counter_load_oe_param_if #(.WIDTH(W)) bus1 ();

  assign bus0.EN   = en;
  assign bus0.LD   = ld;
  assign bus0.OE   = oe;
  assign bus0.UP   = up;
  assign bus0.MODE = mode;
  assign bus0.D    = d;

  assign bus1.EN   = bus0.TC;
  assign bus1.LD   = 1'b0;
  assign bus1.OE   = 1'b1;
  assign bus1.UP   = 1'b1;
  assign bus1.MODE = 2'b00;
  assign bus1.D    = '0;

  counter_load_oe_param #(.WIDTH(W), .MAX_VAL(MV)) u_stage0 (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus0.slave)
  );

  counter_load_oe_param #(.WIDTH(W), .MAX_VAL(MV)) u_stage1 (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_tc0();
    int tv;
    tv = up ? MV : 0;
    return (rst_n && en && !ld && !m_halt0 && (m_cnt0 == tv)) ? 1 : 0;
  endfunction

  function automatic int m_tc1();
    return (m_tc0() == 1 && m_cnt1 == MV) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_cnt0  = 0;
    m_cnt1  = 0;
    m_done0 = 0;
    m_halt0 = 0;
  endtask

  // one clock edge of the cascade described by the counting rules
  task automatic model_edge();
    int tc0;
    tc0 = m_tc0();
    if (ld) begin
      m_cnt0  = (int'(d) > MV) ? MV : int'(d);
      m_done0 = 0;
      m_halt0 = 0;
    end else if (en && !m_halt0) begin
      if (m_cnt0 != (up ? MV : 0)) begin
        m_cnt0 = up ? m_cnt0 + 1 : m_cnt0 - 1;
      end else if (mode == 2'b10) begin
        m_done0 = 1;
        m_halt0 = 1;
      end else if (mode != 2'b01) begin
        m_cnt0 = up ? 0 : MV;
      end
    end
    if (tc0 == 1) m_cnt1 = (m_cnt1 == MV) ? 0 : m_cnt1 + 1;
  endtask

  // inputs are applied at a negedge before calling; checks TC pre-edge and Y/DONE post-edge
  task automatic tick();
    #1;
    check("tc0", int'(bus0.TC), m_tc0());
    check("tc1", int'(bus1.TC), m_tc1());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("y0", int'(bus0.Y), oe ? m_cnt0 : 0);
    check("done0", int'(bus0.DONE), int'(m_done0));
    check("y1", int'(bus1.Y), m_cnt1);
    if (prev_y0 == MV && int'(bus0.Y) == 0 && oe) falls0++;
    if (prev_y1 == MV && int'(bus1.Y) == 0) falls1++;
    prev_y0 = int'(bus0.Y);
    prev_y1 = int'(bus1.Y);
  endtask

  // drop reset between edges and confirm outputs clear without a clock
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_y0", int'(bus0.Y), 0);
    check("arst_done", int'(bus0.DONE), 0);
    check("arst_tc0", int'(bus0.TC), 0);
    check("arst_y1", int'(bus1.Y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_y0 = 0;
    prev_y1 = 0;
  endtask

  task automatic load(input int val);
    ld = 1'b1;
    d  = W'(val);
    tick();
    ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; ld = 1'b0; oe = 1'b1; up = 1'b0; mode = 2'b00; d = '0;
    model_reset();
    prev_y0 = 0; prev_y1 = 0; falls0 = 0; falls1 = 0;

    // reset held across edges: everything stays 0 even with EN=1, UP=0
    @(negedge clk);
    @(negedge clk);
    check("rst_y0", int'(bus0.Y), 0);
    check("rst_tc0", int'(bus0.TC), 0);
    check("rst_done", int'(bus0.DONE), 0);
    check("rst_y1", int'(bus1.Y), 0);
    rst_n = 1'b1;

    // wrap up-count: 1..9,0,1,2
    up = 1'b1; mode = 2'b00;
    for (int i = 0; i < 12; i++) tick();
    check("wrap_end", int'(bus0.Y), 2);

    // clamped load then saturating down-count
    load(12);
    check("clamp", int'(bus0.Y), MV);
    up = 1'b0; mode = 2'b01;
    for (int i = 0; i < 12; i++) tick();
    check("sat_y", int'(bus0.Y), 0);
    #1;
    check("sat_tc", int'(bus0.TC), 1);

    // one-shot: 7 -> 8 -> 9 -> halt, EN toggling ignored, LD releases
    up = 1'b1; mode = 2'b10;
    load(7);
    for (int i = 0; i < 4; i++) tick();
    check("shot_y", int'(bus0.Y), MV);
    check("shot_done", int'(bus0.DONE), 1);
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      tick();
    end
    en = 1'b1; mode = 2'b10;
    load(3);
    check("rel_y", int'(bus0.Y), 3);
    check("rel_done", int'(bus0.DONE), 0);
    tick(); tick();

    // output enable gates Y only
    mode = 2'b00;
    load(2);
    oe = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    oe = 1'b1;
    #1;
    check("oe_y", int'(bus0.Y), 5);
    @(negedge clk);

    // async reset mid-count at 6, then restart from 1
    load(5);
    tick();
    check("pre_arst", int'(bus0.Y), 6);
    async_reset();
    tick();
    check("post_arst", int'(bus0.Y), 1);

    // randomized mix of all controls with occasional async resets
    for (int i = 0; i < 500; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      d  = W'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      oe = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) async_reset();
      tick();
    end

    // cascade: 100 enabled clocks from reset return both stages to 0
    ld = 1'b0; en = 1'b1; oe = 1'b1; up = 1'b1; mode = 2'b00;
    async_reset();
    falls0 = 0; falls1 = 0;
    for (int i = 0; i < 100; i++) tick();
    check("casc_y0", int'(bus0.Y), 0);
    check("casc_y1", int'(bus1.Y), 0);
    check("casc_wraps0", falls0, 10);
    check("casc_wraps1", falls1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_load_oe_param.md
Name: counter_load_oe_param

Overview:
- Parametrised successor to the team's 4-bit enable/load/output-enable counter.
- Adds generic width, a programmable modulus and up/down direction.
- Adds three terminal-count modes: wrap, saturate and one-shot.
- Provides a cascadable terminal-count output and a sticky DONE flag, for use as a timebase, event counter or frame/line counter in datapath and display control blocks.

Parameters:
- WIDTH, 4: counter and data width in bits (≥2).
- MAX_VAL, 2**WIDTH-1: highest count value; the count range is 0..MAX_VAL (MAX_VAL ≤ 2**WIDTH-1).

Ports:
- clk  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  count enable.
- LD  in  1  synchronous parallel load.
- OE  in  1  output enable; 0 forces Y to all zeros.
- UP  in  1  direction: 1 counts up, 0 counts down.
- MODE  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- D  in  WIDTH  load value.
- Y  out  WIDTH  gated count.
- TC  out  1  terminal count (combinational, for cascading).
- DONE  out  1  one-shot finished flag (registered, sticky).

Behaviour:
- Reset (RST_N=0, asynchronous): count=0, DONE=0, state=RUN. Y=0 and TC=0 while reset is held. Release takes effect at the next clk edge.
- Internal register `cnt[WIDTH-1:0]`. Y = OE ? cnt : 0. OE has no effect on `cnt`, TC or DONE.
- Terminal value TV = MAX_VAL when UP=1, 0 when UP=0.
- TC = EN & (cnt==TV) & ~LD, combinational. Chain counters by driving the next stage's EN from TC.
- Per rising edge, priority order is LD, then EN, then hold.
  - LD=1: cnt ← (D > MAX_VAL) ? MAX_VAL : D; DONE ← 0; state ← RUN. LD wins over EN regardless of EN.
  - EN=1, LD=0, cnt≠TV: cnt ← cnt+1 when UP=1, cnt−1 when UP=0.
  - EN=1, LD=0, cnt==TV, MODE 00/11 (wrap): cnt ← 0 when UP=1, MAX_VAL when UP=0.
  - EN=1, LD=0, cnt==TV, MODE 01 (saturate): cnt holds at TV.
  - EN=1, LD=0, cnt==TV, MODE 10 (one-shot): cnt holds; DONE ← 1; state ← HALT.
  - EN=0: cnt holds.
- State machine, two states:
  - RUN: normal counting.
  - HALT: entered only in one-shot mode at terminal count. EN is ignored; cnt and DONE hold. Leaves HALT only on LD (to RUN) or reset.
  - While in HALT, TC=0.
- Changing MODE away from one-shot while in HALT does not release HALT; only LD or reset does.
- Changing UP mid-count takes effect on the next enabled edge. TV and TC follow UP immediately.
- Non-power-of-two MAX_VAL: values above MAX_VAL are never reached by counting. A loaded D > MAX_VAL clamps to MAX_VAL.
- Arithmetic is WIDTH bits, unsigned. Wrap is explicit, never a natural overflow, so MAX_VAL < 2**WIDTH-1 wraps correctly.
- Latency: one clk from an LD/EN edge to Y. OE→Y and EN/UP→TC are zero-cycle (combinational).
- Reset asserted mid-count or in HALT returns everything to reset values immediately, without waiting for clk.

Test Plan (instance WIDTH=4, MAX_VAL=9 unless noted):
1. Reset, then EN=1 UP=1 MODE=00 OE=1 for 12 clocks -> Y sequence 1,2,…,9,0,1,2. TC=1 exactly in the cycle cnt=9.
2. LD=1 D=4'b1100 (12) for one clock with EN=1 -> cnt=9 (clamped). LD=0 UP=0 MODE=01, 12 clocks -> Y counts 8…0, then holds 0. TC stays 1 while cnt=0 and EN=1.
3. MODE=10 UP=1, load 7, EN=1 -> Y 8, 9, then 9 held. DONE=1 from the edge after cnt=9. EN toggled has no effect. LD D=3 -> DONE=0, Y=3, counting resumes.
4. OE=0 for 3 clocks while counting from 2 -> Y=0 during those clocks. OE=1 -> Y=5 (count continued internally).
5. Drop RST_N asynchronously between clock edges at cnt=6 in HALT/RUN -> Y, DONE immediately 0. Release -> counting restarts from 1 on the first enabled edge.
6. Cascade two instances (WIDTH=4, MAX_VAL=9): stage-1 EN = stage-0 TC. 100 enabled clocks -> {stage-1, stage-0} = 0,0 with both wraps observed. Stage-1 increments only on stage-0 9→0 edges.
